// File: rtl/vram_dpb_fill.sv
// rtl/vram_dpb_fill.sv - true-dual-port video RAM with a whole-array fill engine on port A
// Port A serves the CPU side, port B the video readout; the fill engine borrows port A while busy.
module vram_dpb_fill #(
  parameter int               DATA_W        = 8,
  parameter int               ADDR_W        = 10,
  parameter logic [DATA_W-1:0] RESET_FILL   = 8'h20,
  parameter bit               FILL_ON_RESET = 1'b1,
  parameter bit               OUT_REG       = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_ready,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  output logic [DATA_W-1:0] b_dout,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   fill_addr;
  logic [DATA_W-1:0]   fill_val;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   a_q, b_q;

  logic                wa_en;
  logic [ADDR_W-1:0]   wa_addr;
  logic [DATA_W-1:0]   wa_data;
  logic                wb_en;

  assign a_ready = !fill_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL_ON_RESET ? FILL : IDLE;
      fill_busy <= FILL_ON_RESET;
      fill_addr <= '0;
      fill_val  <= RESET_FILL;
      fill_done <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      if (fill_start) begin
        state     <= FILL;
        fill_busy <= 1'b1;
        fill_addr <= '0;
        fill_val  <= fill_value;
      end else if (state == FILL) begin
        if (fill_addr == {ADDR_W{1'b1}}) begin
          state     <= IDLE;
          fill_busy <= 1'b0;
          fill_done <= 1'b1;
          fill_addr <= '0;
        end else begin
          fill_addr <= fill_addr + 1'b1;
        end
      end
    end
  end

  // The fill engine owns port A's write path; a reset cycle must not write stale fill state.
  always_comb begin
    wa_en   = 1'b0;
    wa_addr = a_addr;
    wa_data = a_din;
    if (fill_busy) begin
      wa_en   = !reset;
      wa_addr = fill_addr;
      wa_data = fill_val;
    end else begin
      wa_en   = a_en && a_we;
    end
  end

  assign wb_en = b_en && b_we && !(wa_en && (wa_addr == b_addr));

  always_ff @(posedge clk) begin
    if (wa_en) mem[wa_addr] <= wa_data;
    if (wb_en) mem[b_addr]  <= b_din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (a_en && !a_we && !fill_busy) a_q <= mem[a_addr];
      if (b_en && !b_we)               b_q <= mem[b_addr];
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [DATA_W-1:0] a_q2, b_q2;
      always_ff @(posedge clk) begin
        if (reset) begin
          a_q2 <= '0;
          b_q2 <= '0;
        end else begin
          a_q2 <= a_q;
          b_q2 <= b_q;
        end
      end
      assign a_dout = a_q2;
      assign b_dout = b_q2;
    end else begin : g_no_out_reg
      assign a_dout = a_q;
      assign b_dout = b_q;
    end
  endgenerate

endmodule

// File: tb/tb_vram_dpb_fill.sv
// tb/tb_vram_dpb_fill.sv - directed plus randomized checks of vram_dpb_fill against an array model
// Main instance: 8x1024 with output register; second instance: 16x2048 without it.
module tb_vram_dpb_fill;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       a_en = 0, a_we = 0, b_en = 0, b_we = 0, fill_start = 0;
  logic [9:0] a_addr = 0, b_addr = 0;
  logic [7:0] a_din = 0, b_din = 0, fill_value = 0;
  logic [7:0] a_dout, b_dout;
  logic       a_ready, fill_busy, fill_done;

  logic        x_b_en = 0;
  logic [10:0] x_b_addr = 0;
  logic [15:0] x_b_dout, x_a_dout;
  logic        x_a_ready, x_busy, x_done;

  vram_dpb_fill #(.DATA_W(8), .ADDR_W(10), .RESET_FILL(8'h20), .FILL_ON_RESET(1'b1), .OUT_REG(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .a_ready(a_ready),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout),
    .fill_start(fill_start), .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done));

  vram_dpb_fill #(.DATA_W(16), .ADDR_W(11), .RESET_FILL(16'h0720), .FILL_ON_RESET(1'b1), .OUT_REG(1'b0)) u_dut16 (
    .clk(clk), .reset(reset),
    .a_en(1'b0), .a_we(1'b0), .a_addr(11'd0), .a_din(16'd0), .a_dout(x_a_dout), .a_ready(x_a_ready),
    .b_en(x_b_en), .b_we(1'b0), .b_addr(x_b_addr), .b_din(16'd0), .b_dout(x_b_dout),
    .fill_start(1'b0), .fill_value(16'd0), .fill_busy(x_busy), .fill_done(x_done));

  int checks = 0;
  int errors = 0;
  logic [7:0] model [1024];
  logic [7:0] last_a;
  logic [7:0] rd;
  logic [15:0] rd16;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_fill(input logic [7:0] v);
    for (int i = 0; i < 1024; i++) model[i] = v;
  endtask

  task automatic write_a(input logic [9:0] ad, input logic [7:0] d);
    a_en = 1; a_we = 1; a_addr = ad; a_din = d;
    tick();
    a_en = 0; a_we = 0;
    model[ad] = d;
  endtask

  task automatic write_b(input logic [9:0] ad, input logic [7:0] d);
    b_en = 1; b_we = 1; b_addr = ad; b_din = d;
    tick();
    b_en = 0; b_we = 0;
    model[ad] = d;
  endtask

  task automatic read_b(input logic [9:0] ad, output logic [7:0] d);
    b_en = 1; b_we = 0; b_addr = ad;
    tick();
    b_en = 0;
    tick();
    d = b_dout;
  endtask

  task automatic read_a(input logic [9:0] ad, output logic [7:0] d);
    a_en = 1; a_we = 0; a_addr = ad;
    tick();
    a_en = 0;
    tick();
    d = a_dout;
    last_a = model[ad];
  endtask

  task automatic read_x(input logic [10:0] ad, output logic [15:0] d);
    x_b_en = 1; x_b_addr = ad;
    tick();
    x_b_en = 0;
    d = x_b_dout;
  endtask

  // Counts clocks until the main instance drops fill_busy; 0 means it never did.
  task automatic wait_idle(output int n, output logic done);
    n = 0; done = 0;
    for (int i = 1; i <= 5000; i++) begin
      tick();
      if (!fill_busy) begin
        n = i; done = fill_done;
        break;
      end
    end
  endtask

  initial begin
    int n8, n16, n;
    logic d8, d16, dn;
    int bad;
    logic [9:0] ra, rb;
    logic [7:0] da, db, old;

    // Reset and the reset-triggered fill on both instances
    tick();
    check("rst_a_dout", a_dout, 8'h00);
    check("rst_b_dout", b_dout, 8'h00);
    check("rst_busy", fill_busy, 1'b1);
    check("rst_done", fill_done, 1'b0);
    check("rst_ready", a_ready, 1'b0);
    check("rst_busy16", x_busy, 1'b1);
    reset = 0;
    n8 = 0; n16 = 0; d8 = 0; d16 = 0;
    for (int i = 1; i <= 3000; i++) begin
      tick();
      if (n8 == 0 && !fill_busy) begin n8 = i; d8 = fill_done; end
      if (n16 == 0 && !x_busy) begin n16 = i; d16 = x_done; end
      if (n8 != 0 && n16 != 0) break;
    end
    check("reset_fill_cycles", n8, 1024);
    check("reset_fill_done", d8, 1'b1);
    check("reset_fill_cycles16", n16, 2048);
    check("reset_fill_done16", d16, 1'b1);
    tick();
    check("done_one_cycle", fill_done, 1'b0);
    check("ready_after_fill", a_ready, 1'b1);
    model_fill(8'h20);
    read_b(10'h000, rd); check("fill_b_000", rd, 8'h20);
    read_b(10'h3FF, rd); check("fill_b_3ff", rd, 8'h20);
    read_x(11'h000, rd16); check("fill16_000", rd16, 16'h0720);
    read_x(11'h7FF, rd16); check("fill16_7ff", rd16, 16'h0720);

    // A write then B read, checking the two-clock latency
    write_a(10'h005, 8'h41);
    b_en = 1; b_addr = 10'h005;
    tick();
    b_en = 0;
    check("lat_stage1_hold", b_dout, 8'h20);
    tick();
    check("lat_b_005", b_dout, 8'h41);
    read_a(10'h005, rd); check("a_read_005", rd, 8'h41);

    // Commanded fill; port A is locked out meanwhile
    fill_start = 1; fill_value = 8'h00;
    tick();
    fill_start = 0;
    check("start_busy", fill_busy, 1'b1);
    check("start_ready", a_ready, 1'b0);
    a_en = 1; a_we = 1; a_addr = 10'h010; a_din = 8'hFF;
    tick();
    a_we = 0; a_addr = 10'h020;
    tick();
    a_en = 0;
    tick();
    check("a_dout_holds", a_dout, last_a);
    wait_idle(n, dn);
    check("cmd_fill_cycles", n + 3, 1024);
    check("cmd_fill_done", dn, 1'b1);
    model_fill(8'h00);
    read_b(10'h010, rd); check("ignored_write", rd, 8'h00);

    // Same-address collisions
    a_en = 1; a_we = 1; a_addr = 10'h020; a_din = 8'hAA;
    b_en = 1; b_we = 1; b_addr = 10'h020; b_din = 8'h55;
    tick();
    a_en = 0; a_we = 0; b_en = 0; b_we = 0;
    model[10'h020] = 8'hAA;
    read_b(10'h020, rd); check("ww_collision_b", rd, 8'hAA);
    read_a(10'h020, rd); check("ww_collision_a", rd, 8'hAA);
    write_a(10'h030, 8'h5A);
    a_en = 1; a_we = 1; a_addr = 10'h030; a_din = 8'hC3;
    b_en = 1; b_we = 0; b_addr = 10'h030;
    tick();
    a_en = 0; a_we = 0; b_en = 0;
    tick();
    check("rw_collision_old", b_dout, 8'h5A);
    model[10'h030] = 8'hC3;
    read_b(10'h030, rd); check("rw_collision_new", rd, 8'hC3);

    // Reset mid-fill at address 0x200 reruns the full reset fill
    fill_start = 1; fill_value = 8'h77;
    tick();
    fill_start = 0;
    repeat (10'h200) tick();
    reset = 1;
    tick();
    check("midfill_reset_busy", fill_busy, 1'b1);
    reset = 0;
    wait_idle(n, dn);
    check("midfill_reset_cycles", n, 1024);
    model_fill(8'h20);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      read_b(i[9:0], rd);
      if (rd !== model[i]) bad++;
    end
    check("midfill_reset_words_bad", bad, 0);

    // Re-issued fill_start restarts from address 0
    fill_start = 1; fill_value = 8'h11;
    tick();
    fill_start = 0;
    repeat (99) tick();
    fill_start = 1; fill_value = 8'h22;
    tick();
    fill_start = 0;
    wait_idle(n, dn);
    check("restart_cycles", n, 1024);
    model_fill(8'h22);
    read_b(10'h000, rd); check("restart_000", rd, 8'h22);
    read_b(10'h1FF, rd); check("restart_1ff", rd, 8'h22);
    read_b(10'h3FF, rd); check("restart_3ff", rd, 8'h22);

    // Random traffic against the array model; narrow address range to provoke collisions
    for (int k = 0; k < 400; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
      rb = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
      da = 8'($urandom); db = 8'($urandom);
      case ($urandom_range(0, 4))
        0: write_a(ra, da);
        1: write_b(rb, db);
        2: begin
          a_en = 1; a_we = 1; a_addr = ra; a_din = da;
          b_en = 1; b_we = 1; b_addr = rb; b_din = db;
          tick();
          a_en = 0; a_we = 0; b_en = 0; b_we = 0;
          model[rb] = db;
          model[ra] = da;
        end
        3: begin read_b(rb, rd); check("rand_read_b", rd, model[rb]); end
        default: begin read_a(ra, rd); check("rand_read_a", rd, model[ra]); end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
